// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int RELOCK_W = 8;

    // Width of the shared state counter; it only ever has to reach the largest phase length minus one.
    function automatic int cnt_width(input int rst_cycles, input int lock_timeout, input int stable_cycles);
        int m;
        m = (rst_cycles > lock_timeout) ? rst_cycles : lock_timeout;
        m = (stable_cycles > m) ? stable_cycles : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// PLL-facing and system-facing signals of the reset sequencer.
interface pll_reset_ctrl_if;
    import pll_rst_pkg::*;

    logic                pll_lock;
    logic                pll_reset;
    logic                sys_reset;
    logic                ready;
    logic                lock_fail;
    logic [RELOCK_W-1:0] relock_cnt;

    modport master (
        input  pll_lock,
        output pll_reset, sys_reset, ready, lock_fail, relock_cnt
    );

    modport slave (
        output pll_lock,
        input  pll_reset, sys_reset, ready, lock_fail, relock_cnt
    );

endinterface

// File: rtl/pll_reset_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clkin domain.
module lock_sync (
    input  logic clkin,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter; cleared to "unlocked" by reset.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock monitor. Optional RUN-state loss filter: define
// PLL_RST_CTRL_LOSS_FILTER_EN to require LOSS_FILTER consecutive low lock samples.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 8,
    parameter int LOSS_FILTER   = 4
) (
    input  logic              clkin,
    input  logic              reset,
    pll_reset_ctrl_if.master  bus
);

    localparam int CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]    RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX  = {RELOCK_W{1'b1}};

    pll_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                lock_fail_q, lock_fail_d;
    logic                pll_reset_q, pll_reset_d;
    logic                sys_reset_q, sys_reset_d;
    logic                ready_q, ready_d;
    logic                lock_s;
    logic                loss_s;
    logic                timeout_s;

    lock_sync u_lock_sync (
        .clkin   (clkin),
        .reset   (reset),
        .async_i (bus.pll_lock),
        .sync_o  (lock_s)
    );

`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
    localparam int FILT_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);

    logic [FILT_W-1:0] filt_q, filt_d;

    // Length of the current run of low lock samples while running.
    always_comb begin
        filt_d = {FILT_W{1'b0}};
        if ((state_q == RUN) && !lock_s && (filt_q != FILT_LAST)) begin
            filt_d = filt_q + 1'b1;
        end else begin
            filt_d = {FILT_W{1'b0}};
        end
    end

    // Loss filter run-length register.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            filt_q <= {FILT_W{1'b0}};
        end else begin
            filt_q <= filt_d;
        end
    end

    assign loss_s = (state_q == RUN) && !lock_s && (filt_q == FILT_LAST);
`else
    logic [31:0] loss_filter_unused_s;
    assign loss_filter_unused_s = 32'(LOSS_FILTER);
    assign loss_s = (state_q == RUN) && !lock_s;
`endif

    // State, shared counter and statistics registers.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= {CNT_W{1'b0}};
            retry_q     <= {RETRY_W{1'b0}};
            relock_q    <= {RELOCK_W{1'b0}};
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    // Next-state logic; a lock arriving on the timeout cycle takes priority.
    always_comb begin
        state_d   = state_q;
        timeout_s = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                else                   state_d = PLL_RST;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = PLL_RST;
                    timeout_s = 1'b1;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!lock_s)                   state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
                else                           state_d = STABLE;
            end
            RUN: begin
                if (loss_s) state_d = PLL_RST;
                else        state_d = RUN;
            end
            default: state_d = PLL_RST;
        endcase

        // Counter restarts on every state entry and idles in RUN.
        if ((state_d != state_q) || (state_q == RUN)) cnt_d = {CNT_W{1'b0}};
        else                                          cnt_d = cnt_q + 1'b1;

        if ((state_q == STABLE) && (state_d == RUN))       retry_d = {RETRY_W{1'b0}};
        else if (timeout_s && (retry_q != RETRY_MAX))      retry_d = retry_q + 1'b1;
        else                                               retry_d = retry_q;

        if (loss_s && (relock_q != RELOCK_MAX)) relock_d = relock_q + 1'b1;
        else                                    relock_d = relock_q;

        lock_fail_d = lock_fail_q | (retry_d == RETRY_MAX);
    end

    // Output decode from the next state so outputs change with the state register.
    always_comb begin
        pll_reset_d = 1'b1;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
        case (state_d)
            PLL_RST:   begin pll_reset_d = 1'b1; sys_reset_d = 1'b1; ready_d = 1'b0; end
            WAIT_LOCK: begin pll_reset_d = 1'b0; sys_reset_d = 1'b1; ready_d = 1'b0; end
            STABLE:    begin pll_reset_d = 1'b0; sys_reset_d = 1'b1; ready_d = 1'b0; end
            RUN:       begin pll_reset_d = 1'b0; sys_reset_d = 1'b0; ready_d = 1'b1; end
            default:   begin pll_reset_d = 1'b1; sys_reset_d = 1'b1; ready_d = 1'b0; end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.sys_reset  = sys_reset_q;
    assign bus.ready      = ready_q;
    assign bus.lock_fail  = lock_fail_q;
    assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl (RST=4, TIMEOUT=32, STABLE=8, MAX_RETRY=3, FILTER=4).
module tb_pll_reset_ctrl;

`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
    localparam int DROP_LEN = 4;
    localparam int LOSS_LAT = 6;
`else
    localparam int DROP_LEN = 1;
    localparam int LOSS_LAT = 3;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pll_reset_ctrl_if bus ();

    pll_reset_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (3),
        .LOSS_FILTER   (4)
    ) dut (
        .clkin (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic pr, input logic sr, input logic rd,
                           input logic lf, input logic [7:0] rc);
        chk({tag, ".pll_reset"},  32'(bus.pll_reset),  32'(pr));
        chk({tag, ".sys_reset"},  32'(bus.sys_reset),  32'(sr));
        chk({tag, ".ready"},      32'(bus.ready),      32'(rd));
        chk({tag, ".lock_fail"},  32'(bus.lock_fail),  32'(lf));
        chk({tag, ".relock_cnt"}, 32'(bus.relock_cnt), 32'(rc));
    endtask

    // From RUN: drop lock, check the loss lands exactly LOSS_LAT edges after the drop.
    task automatic lose_lock(input string tag, input logic [7:0] exp_relock, input logic exp_fail);
        bus.pll_lock = 1'b0;
        tick(DROP_LEN);
        bus.pll_lock = 1'b1;
        tick(LOSS_LAT - DROP_LEN - 1);
        chk({tag, ".ready_before"}, 32'(bus.ready), 32'd1);
        tick(1);
        chk_out({tag, ".loss"}, 1'b1, 1'b1, 1'b0, exp_fail, exp_relock);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.pll_lock = 1'b0;
        tick(2);
        chk_out("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        // 1: power-up sequence, lock 10 cycles after release
        rst = 1'b0;
        tick(3);
        chk("t1.pll_reset_e3", 32'(bus.pll_reset), 32'd1);
        tick(1);
        chk("t1.pll_reset_e4", 32'(bus.pll_reset), 32'd0);
        tick(6);
        bus.pll_lock = 1'b1;
        tick(10);
        chk("t1.sys_reset_l10", 32'(bus.sys_reset), 32'd1);
        chk("t1.ready_l10",     32'(bus.ready),     32'd0);
        tick(1);
        chk_out("t1.run", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        // 4: lock loss in RUN
`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        tick(8);
        chk_out("t4.glitch", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif
        lose_lock("t4", 8'd1, 1'b0);
        tick(3);
        chk("t4.pulse_3", 32'(bus.pll_reset), 32'd1);
        tick(1);
        chk("t4.pulse_4", 32'(bus.pll_reset), 32'd0);
        tick(8);
        chk("t4.sys_reset_12", 32'(bus.sys_reset), 32'd1);
        tick(1);
        chk_out("t4.rerun", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

        // 5: relock counter saturation
        for (int i = 0; i < 254; i++) begin
            bus.pll_lock = 1'b0;
            tick(DROP_LEN);
            bus.pll_lock = 1'b1;
            tick(LOSS_LAT - DROP_LEN + 15);
        end
        chk("t5.relock_255", 32'(bus.relock_cnt), 32'd255);
        chk("t5.ready_255",  32'(bus.ready),      32'd1);
        for (int i = 0; i < 45; i++) begin
            bus.pll_lock = 1'b0;
            tick(DROP_LEN);
            bus.pll_lock = 1'b1;
            tick(LOSS_LAT - DROP_LEN + 15);
        end
        chk("t5.relock_300", 32'(bus.relock_cnt), 32'd255);
        chk("t5.ready_300",  32'(bus.ready),      32'd1);

        // 6a: asynchronous reset in RUN
        tick(3);
        rst = 1'b1;
        #1;
        chk_out("t6.run_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bus.pll_lock = 1'b0;
        tick(2);

        // 2: no lock, timeouts every 36 cycles, lock_fail on the third
        rst = 1'b0;
        tick(35);
        chk("t2.pll_reset_e35", 32'(bus.pll_reset), 32'd0);
        tick(1);
        chk("t2.pll_reset_e36", 32'(bus.pll_reset), 32'd1);
        chk("t2.lock_fail_e36", 32'(bus.lock_fail), 32'd0);
        tick(3);
        chk("t2.pll_reset_e39", 32'(bus.pll_reset), 32'd1);
        tick(1);
        chk("t2.pll_reset_e40", 32'(bus.pll_reset), 32'd0);
        tick(32);
        chk("t2.pll_reset_e72", 32'(bus.pll_reset), 32'd1);
        chk("t2.lock_fail_e72", 32'(bus.lock_fail), 32'd0);
        tick(35);
        chk("t2.lock_fail_e107", 32'(bus.lock_fail), 32'd0);
        tick(1);
        chk("t2.lock_fail_e108", 32'(bus.lock_fail), 32'd1);
        chk("t2.pll_reset_e108", 32'(bus.pll_reset), 32'd1);

        // 3: short lock during STABLE, then a real lock restarts the stable count
        tick(4);
        bus.pll_lock = 1'b1;
        tick(5);
        bus.pll_lock = 1'b0;
        tick(2);
        chk("t3.sys_reset_stable", 32'(bus.sys_reset), 32'd1);
        tick(1);
        chk_out("t3.back_wait", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        tick(2);
        bus.pll_lock = 1'b1;
        tick(10);
        chk("t3.sys_reset_l10", 32'(bus.sys_reset), 32'd1);
        tick(1);
        chk_out("t3.run", 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);

        // 6b: asynchronous reset during a PLL reset pulse
        lose_lock("t6", 8'd1, 1'b1);
        tick(1);
        chk("t6.in_pll_rst", 32'(bus.pll_reset), 32'd1);
        rst = 1'b1;
        #1;
        chk_out("t6.pllrst_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("t6.pulse_3", 32'(bus.pll_reset), 32'd1);
        tick(1);
        chk("t6.pulse_4", 32'(bus.pll_reset), 32'd0);
        tick(8);
        chk("t6.sys_reset_12", 32'(bus.sys_reset), 32'd1);
        tick(1);
        chk_out("t6.run", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
